// File: rtl/mux_8x1_rr_sched.sv
// Round-robin burst scheduler sharing one mux_8x1 datapath among eight requesters.
// Define MUX_8X1_SCHED_LOCK_EN to add lock_i, which holds a grant past MAX_BEATS.

module mux_8x1 (
   input  logic [7:0] array_i,
   input  logic [2:0] sel_i,
   output logic       out_o
);
   assign out_o = array_i[sel_i];
endmodule

module mux_8x1_rr_sched #(
   parameter int unsigned MAX_BEATS = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] req_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
`ifdef MUX_8X1_SCHED_LOCK_EN
   input  logic       lock_i,
`endif
   output logic [2:0] sel_o,
   output logic [7:0] gnt_o,
   output logic       valid_o,
   output logic       data_o
);
   localparam int unsigned   CW   = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_BEATS - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        r_state;
   logic [2:0]    r_sel;
   logic [2:0]    r_ptr;
   logic [7:0]    r_gnt;
   logic [CW-1:0] r_cnt;

   logic       w_mux, w_valid, w_beat, w_last, w_lock;
   logic       w_rel_a, w_rel_b, w_arb, w_found;
   logic [2:0] w_win, w_idx;

   mux_8x1 u_mux (
      .array_i (data_i),
      .sel_i   (r_sel),
      .out_o   (w_mux)
   );

`ifdef MUX_8X1_SCHED_LOCK_EN
   assign w_lock = lock_i;
`else
   assign w_lock = 1'b0;
`endif

   assign w_valid = (r_state == GRANT) & req_i[r_sel];
   assign w_beat  = w_valid & ready_i;
   assign w_last  = (r_cnt == LAST);
   assign w_rel_a = w_beat & w_last & ~w_lock;
   // A dropped request releases without a beat, so nothing is lost.
   assign w_rel_b = (r_state == GRANT) & ~req_i[r_sel];
   assign w_arb   = (r_state == IDLE) | w_rel_a | w_rel_b;

   // First set request scanning upward from r_ptr with wrap-around.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = r_ptr;
      for (int i = 0; i < 8; i++) begin
         w_idx = r_ptr + 3'(i);
         if (!w_found && req_i[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_sel   <= 3'd0;
         r_ptr   <= 3'd0;
         r_gnt   <= 8'd0;
         r_cnt   <= '0;
      end else if (w_arb) begin
         if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_win;
            r_gnt   <= 8'b1 << w_win;
            r_ptr   <= w_win + 3'd1;
            r_cnt   <= '0;
         end else begin
            r_state <= IDLE;
            r_gnt   <= 8'd0;
         end
      end else if (w_beat && !(w_last && w_lock)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign sel_o   = r_sel;
   assign gnt_o   = r_gnt;
   assign valid_o = w_valid;
   assign data_o  = w_mux & w_valid;
endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
// Directed bench for mux_8x1_rr_sched: default MAX_BEATS=4 instance plus a MAX_BEATS=1 instance.
module tb_mux_8x1_rr_sched;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req, data;
   logic       ready;
`ifdef MUX_8X1_SCHED_LOCK_EN
   logic       lock;
`endif
   logic [2:0] sel, sel1;
   logic [7:0] gnt, gnt1;
   logic       valid, valid1, dout, dout1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mux_8x1_rr_sched #(.MAX_BEATS(4)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .data_i  (data),
      .ready_i (ready),
`ifdef MUX_8X1_SCHED_LOCK_EN
      .lock_i  (lock),
`endif
      .sel_o   (sel),
      .gnt_o   (gnt),
      .valid_o (valid),
      .data_o  (dout)
   );

   mux_8x1_rr_sched #(.MAX_BEATS(1)) u_dut1 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .data_i  (data),
      .ready_i (ready),
`ifdef MUX_8X1_SCHED_LOCK_EN
      .lock_i  (lock),
`endif
      .sel_o   (sel1),
      .gnt_o   (gnt1),
      .valid_o (valid1),
      .data_o  (dout1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] e;
      rst_n = 1'b1; req = 8'h00; data = 8'h00; ready = 1'b0;
`ifdef MUX_8X1_SCHED_LOCK_EN
      lock = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h00);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_data", 32'(dout), 32'h0);
      nxt();
      rst_n = 1'b1;

      // idle with no requests
      for (int c = 0; c < 5; c++) begin
         nxt();
         chk("idle_gnt", 32'(gnt), 32'h00);
         chk("idle_valid", 32'(valid), 32'h0);
         chk("idle_sel", 32'(sel), 32'h0);
      end

      // lone requester 0: regranted with no bubble
      req = 8'h01; data = 8'h01; ready = 1'b1;
      #1 chk("req0_pre", 32'(valid), 32'h0);
      nxt();
      for (int c = 0; c < 10; c++) begin
         chk("req0_gnt", 32'(gnt), 32'h01);
         chk("req0_valid", 32'(valid), 32'h1);
         chk("req0_data", 32'(dout), 32'h1);
         nxt();
      end
      req = 8'h00;
      #1 chk("req0_drop_valid", 32'(valid), 32'h0);
      nxt();
      chk("req0_idle_gnt", 32'(gnt), 32'h00);

      // all requesting: 4-beat rotation, and every-beat rotation for MAX_BEATS=1
      do_reset();
      req = 8'hFF; data = 8'b1011_0010;
      nxt();
      for (int k = 0; k < 33; k++) begin
         e = 3'((k / 4) % 8);
         chk("walk_sel", 32'(sel), 32'(e));
         chk("walk_valid", 32'(valid), 32'h1);
         chk("walk_data", 32'(dout), 32'(data[e]));
         e = 3'(k % 8);
         chk("walk1_sel", 32'(sel1), 32'(e));
         chk("walk1_gnt", 32'(gnt1), 32'(8'b1 << e));
         chk("walk1_valid", 32'(valid1), 32'h1);
         chk("walk1_data", 32'(dout1), 32'(data[e]));
         nxt();
      end

      // requesters 2 and 5 from ptr=3, drop and stall behaviour
      do_reset();
      req = 8'h04; ready = 1'b1; data = 8'h24;
      nxt();
      chk("p3_sel", 32'(sel), 32'h2);
      req = 8'h00;
      nxt();
      chk("p3_idle", 32'(gnt), 32'h00);
      req = 8'h24;
      nxt();
      chk("d_c0_sel", 32'(sel), 32'h5);
      chk("d_c0_gnt", 32'(gnt), 32'h20);
      chk("d_c0_valid", 32'(valid), 32'h1);
      nxt(); ready = 1'b0;
      #1 chk("d_c1_sel", 32'(sel), 32'h5);
      chk("d_c1_valid", 32'(valid), 32'h1);
      nxt(); ready = 1'b1;
      #1 chk("d_c2_sel", 32'(sel), 32'h5);
      nxt(); ready = 1'b0; req = 8'h04;
      #1 chk("d_c3_valid", 32'(valid), 32'h0);
      chk("d_c3_data", 32'(dout), 32'h0);
      nxt(); req = 8'h24; ready = 1'b1;
      #1 chk("d_c4_sel", 32'(sel), 32'h2);
      chk("d_c4_gnt", 32'(gnt), 32'h04);
      chk("d_c4_valid", 32'(valid), 32'h1);
      for (int c = 5; c <= 10; c++) begin
         nxt(); ready = (c % 2 == 0);
         #1 chk("d_stall_sel", 32'(sel), 32'h2);
      end
      nxt();
      #1 chk("d_c11_sel", 32'(sel), 32'h5);
      chk("d_c11_valid", 32'(valid), 32'h1);

      // reset mid-burst on requester 6
      do_reset();
      req = 8'h40; data = 8'h40; ready = 1'b1;
      nxt();
      chk("r6_sel", 32'(sel), 32'h6);
      nxt(); nxt();
      chk("r6_data", 32'(dout), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("r6_rst_gnt", 32'(gnt), 32'h00);
      chk("r6_rst_sel", 32'(sel), 32'h0);
      chk("r6_rst_valid", 32'(valid), 32'h0);
      chk("r6_rst_data", 32'(dout), 32'h0);
      rst_n = 1'b1;
      nxt();
      chk("r6_regrant", 32'(sel), 32'h6);
      req = 8'h41;
      for (int c = 1; c <= 3; c++) begin
         nxt();
         chk("r6_burst_sel", 32'(sel), 32'h6);
      end
      nxt();
      chk("r6_rotate_sel", 32'(sel), 32'h0);

`ifdef MUX_8X1_SCHED_LOCK_EN
      do_reset();
      lock = 1'b1; req = 8'h03; ready = 1'b1;
      nxt();
      for (int c = 0; c < 10; c++) begin
         chk("lock_sel", 32'(sel), 32'h0);
         nxt();
      end
      lock = 1'b0;
      #1 chk("lock_rel_sel", 32'(sel), 32'h0);
      nxt();
      chk("lock_next_sel", 32'(sel), 32'h1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
